// File: rtl/wb_initiator.sv
// -----------------------------------------------------------------------------
// wb_initiator
//   Turns a simple valid/ready command into a single Wishbone classic cycle.
//   The bus phase ends on wbm_ack_i or after TIMEOUT_CYCLES cycles without ack.
//   The result is then held on a valid/ready response port until it is taken.
//
// Ports
//   wb_clk_i, wb_rst_i          clock, synchronous active-high reset
//   cmd_valid/cmd_ready         command handshake
//   cmd_we/sel/adr/dat          command fields, captured on acceptance
//   rsp_valid/rsp_ready         response handshake
//   rsp_dat, rsp_err            read data (0 for writes/timeouts), timeout flag
//   wbm_*                       Wishbone initiator signals, all registered
//   txn_count                   16-bit wrapping count of ack'd transactions
// -----------------------------------------------------------------------------
module wb_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [3:0]  cmd_sel,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output logic [15:0] txn_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Last counter value before the bus phase gives up.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_r,     state_s;
    logic        cmd_ready_r, cmd_ready_s;
    logic        cyc_r,       cyc_s;
    logic        stb_r,       stb_s;
    logic        we_r,        we_s;
    logic [3:0]  sel_r,       sel_s;
    logic [31:0] adr_r,       adr_s;
    logic [31:0] dat_r,       dat_s;
    logic        rsp_valid_r, rsp_valid_s;
    logic [31:0] rsp_dat_r,   rsp_dat_s;
    logic        rsp_err_r,   rsp_err_s;
    logic [15:0] tmo_cnt_r,   tmo_cnt_s;
    logic [15:0] txn_cnt_r,   txn_cnt_s;

    // Next-state and next-output logic; every register holds unless changed.
    always_comb begin
        state_s     = state_r;
        cmd_ready_s = cmd_ready_r;
        cyc_s       = cyc_r;
        stb_s       = stb_r;
        we_s        = we_r;
        sel_s       = sel_r;
        adr_s       = adr_r;
        dat_s       = dat_r;
        rsp_valid_s = rsp_valid_r;
        rsp_dat_s   = rsp_dat_r;
        rsp_err_s   = rsp_err_r;
        tmo_cnt_s   = tmo_cnt_r;
        txn_cnt_s   = txn_cnt_r;

        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_s     = ST_BUS;
                    cmd_ready_s = 1'b0;
                    cyc_s       = 1'b1;
                    stb_s       = 1'b1;
                    we_s        = cmd_we;
                    sel_s       = cmd_sel;
                    adr_s       = cmd_adr;
                    dat_s       = cmd_dat;
                    tmo_cnt_s   = 16'h0000;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUS: begin
                // Ack is checked first so it wins over a simultaneous timeout.
                if (wbm_ack_i || (tmo_cnt_r == TMO_LAST)) begin
                    state_s     = ST_RESP;
                    cyc_s       = 1'b0;
                    stb_s       = 1'b0;
                    we_s        = 1'b0;
                    sel_s       = 4'h0;
                    adr_s       = 32'h0000_0000;
                    dat_s       = 32'h0000_0000;
                    rsp_valid_s = 1'b1;
                    if (wbm_ack_i) begin
                        rsp_dat_s = we_r ? 32'h0000_0000 : wbm_dat_i;
                        rsp_err_s = 1'b0;
                        txn_cnt_s = txn_cnt_r + 16'd1;
                    end else begin
                        rsp_dat_s = 32'h0000_0000;
                        rsp_err_s = 1'b1;
                    end
                end else begin
                    tmo_cnt_s = tmo_cnt_r + 16'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_s     = ST_IDLE;
                    rsp_valid_s = 1'b0;
                    cmd_ready_s = 1'b1;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s     = ST_IDLE;
                cmd_ready_s = 1'b1;
                cyc_s       = 1'b0;
                stb_s       = 1'b0;
                rsp_valid_s = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_r     <= ST_IDLE;
            cmd_ready_r <= 1'b1;
            cyc_r       <= 1'b0;
            stb_r       <= 1'b0;
            we_r        <= 1'b0;
            sel_r       <= 4'h0;
            adr_r       <= 32'h0000_0000;
            dat_r       <= 32'h0000_0000;
            rsp_valid_r <= 1'b0;
            rsp_dat_r   <= 32'h0000_0000;
            rsp_err_r   <= 1'b0;
            tmo_cnt_r   <= 16'h0000;
            txn_cnt_r   <= 16'h0000;
        end else begin
            state_r     <= state_s;
            cmd_ready_r <= cmd_ready_s;
            cyc_r       <= cyc_s;
            stb_r       <= stb_s;
            we_r        <= we_s;
            sel_r       <= sel_s;
            adr_r       <= adr_s;
            dat_r       <= dat_s;
            rsp_valid_r <= rsp_valid_s;
            rsp_dat_r   <= rsp_dat_s;
            rsp_err_r   <= rsp_err_s;
            tmo_cnt_r   <= tmo_cnt_s;
            txn_cnt_r   <= txn_cnt_s;
        end
    end

    assign cmd_ready = cmd_ready_r;
    assign wbm_cyc_o = cyc_r;
    assign wbm_stb_o = stb_r;
    assign wbm_we_o  = we_r;
    assign wbm_sel_o = sel_r;
    assign wbm_adr_o = adr_r;
    assign wbm_dat_o = dat_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_dat   = rsp_dat_r;
    assign rsp_err   = rsp_err_r;
    assign txn_count = txn_cnt_r;

endmodule

// File: tb/tb_wb_initiator.sv
// -----------------------------------------------------------------------------
// tb_wb_initiator
//   Lockstep bench for wb_initiator (TIMEOUT_CYCLES = 4). Inputs change and
//   outputs are sampled on the falling edge. Expected behaviour per
//   transaction is computed from the transaction outcome rules: number of
//   strobe cycles, error flag, returned data and the running ack count.
// -----------------------------------------------------------------------------
module tb_wb_initiator;

    localparam int TMO = 4;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [3:0]  cmd_sel;
    logic [31:0] cmd_adr, cmd_dat;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_dat;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic [15:0] txn_count;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] exp_count;
    logic [31:0] last_dat;
    logic        last_err;

    wire [70:0] bus = {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o};

    wb_initiator #(.TIMEOUT_CYCLES(TMO)) dut (
        .wb_clk_i (wb_clk_i),  .wb_rst_i (wb_rst_i),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_sel  (cmd_sel),   .cmd_adr  (cmd_adr),   .cmd_dat(cmd_dat),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_dat  (rsp_dat),   .rsp_err  (rsp_err),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .txn_count(txn_count)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Runs one transaction starting at a falling edge in IDLE and ends at the
    // falling edge after the response is consumed (DUT back in IDLE).
    // ack_dly: index of the strobe cycle carrying ack; >= TMO means no ack.
    task automatic do_txn(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                          input logic [31:0] dat, input int ack_dly, input logic [31:0] rdata,
                          input int rsp_wait, input bit hold, input bit spur);
        logic [70:0] exp_bus;
        int          exp_n;
        logic        exp_err;
        logic [31:0] exp_dat;
        exp_err = (ack_dly >= TMO);
        exp_n   = exp_err ? TMO : ack_dly + 1;
        exp_dat = (exp_err || we) ? 32'h0 : rdata;
        if (!exp_err) exp_count = exp_count + 16'd1;
        exp_bus = {2'b11, we, sel, adr, dat};

        n_vec++;
        if (cmd_ready !== 1'b1 || bus !== 71'h0) begin
            n_err++; $display("FAIL idle_before_cmd: cmd_ready=%b bus=%h required 1 / 0", cmd_ready, bus);
        end
        cmd_valid = 1'b1; cmd_we = we; cmd_sel = sel; cmd_adr = adr; cmd_dat = dat;
        @(negedge wb_clk_i);
        cmd_valid = 1'b0; cmd_we = 1'($urandom); cmd_sel = 4'($urandom);
        cmd_adr = $urandom; cmd_dat = $urandom;

        for (int k = 0; k < exp_n; k++) begin
            n_vec++;
            if (bus !== exp_bus || cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin
                n_err++;
                $display("FAIL bus_phase cycle %0d: bus=%h rdy=%b rv=%b required bus=%h rdy=0 rv=0",
                         k, bus, cmd_ready, rsp_valid, exp_bus);
            end
            wbm_ack_i = (k == ack_dly);
            wbm_dat_i = (k == ack_dly) ? rdata : $urandom;
            @(negedge wb_clk_i);
        end
        wbm_ack_i = spur; wbm_dat_i = $urandom; cmd_valid = hold;

        for (int w = 0; w <= rsp_wait; w++) begin
            n_vec++;
            if (bus !== 71'h0 || rsp_valid !== 1'b1 || rsp_dat !== exp_dat || rsp_err !== exp_err ||
                cmd_ready !== 1'b0 || txn_count !== exp_count) begin
                n_err++;
                $display("FAIL resp_phase wait %0d: bus=%h rv=%b dat=%h err=%b rdy=%b cnt=%h required bus=0 rv=1 dat=%h err=%b rdy=0 cnt=%h",
                         w, bus, rsp_valid, rsp_dat, rsp_err, cmd_ready, txn_count, exp_dat, exp_err, exp_count);
            end
            if (w == rsp_wait) rsp_ready = 1'b1;
            @(negedge wb_clk_i);
            wbm_ack_i = 1'b0;
        end
        rsp_ready = 1'b0; cmd_valid = 1'b0;

        n_vec++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || rsp_dat !== exp_dat || rsp_err !== exp_err ||
            bus !== 71'h0 || txn_count !== exp_count) begin
            n_err++;
            $display("FAIL back_to_idle: rv=%b rdy=%b dat=%h err=%b bus=%h cnt=%h required rv=0 rdy=1 dat=%h err=%b bus=0 cnt=%h",
                     rsp_valid, cmd_ready, rsp_dat, rsp_err, bus, txn_count, exp_dat, exp_err, exp_count);
        end
        last_dat = exp_dat; last_err = exp_err;
    endtask

    task automatic test_reset;
        wb_rst_i = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_sel = 4'h0; cmd_adr = 32'h0;
        cmd_dat = 32'h0; rsp_ready = 1'b0; wbm_ack_i = 1'b0; wbm_dat_i = 32'h0;
        repeat (3) @(negedge wb_clk_i);
        n_vec++;
        if (bus !== 71'h0 || rsp_valid !== 1'b0 || rsp_dat !== 32'h0 || rsp_err !== 1'b0 || txn_count !== 16'h0) begin
            n_err++;
            $display("FAIL reset_values: bus=%h rv=%b dat=%h err=%b cnt=%h required all 0",
                     bus, rsp_valid, rsp_dat, rsp_err, txn_count);
        end
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        n_vec++;
        if (cmd_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_cmd_ready: cmd_ready=%b required 1", cmd_ready);
        end
        exp_count = 16'h0; last_dat = 32'h0; last_err = 1'b0;
    endtask

    task automatic test_write_basic;
        do_txn(1'b1, 4'hF, 32'h3000_0000, 32'h0000_0005, 0, 32'hDEAD_BEEF, 0, 1'b0, 1'b0);
    endtask

    task automatic test_read_wait;
        do_txn(1'b0, 4'hF, 32'h3000_0000, 32'hA5A5_0000, 3, 32'h1234_5678, 1, 1'b0, 1'b0);
    endtask

    task automatic test_timeout;
        do_txn(1'b0, 4'h3, 32'h0000_1000, 32'h0, TMO + 2, 32'hFFFF_FFFF, 0, 1'b0, 1'b0);
        do_txn(1'b1, 4'hC, 32'h0000_2000, 32'h1111_2222, TMO, 32'h0, 0, 1'b0, 1'b0);
        do_txn(1'b0, 4'h1, 32'h0000_3000, 32'h0, TMO - 1, 32'hCAFE_F00D, 0, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure;
        do_txn(1'b0, 4'h6, 32'h4000_0040, 32'h0, 1, 32'h0BAD_CAFE, 5, 1'b1, 1'b1);
        do_txn(1'b1, 4'h0, 32'h4000_0044, 32'h7777_8888, 0, 32'h0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 40; i++)
            do_txn(1'($urandom), 4'($urandom), $urandom, $urandom, int'($urandom_range(0, TMO + 1)),
                   $urandom, int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
    endtask

    task automatic test_reset_abort;
        for (int ph = 0; ph < 2; ph++) begin
            cmd_valid = 1'b1; cmd_we = 1'b0; cmd_sel = 4'hF; cmd_adr = $urandom; cmd_dat = $urandom;
            @(negedge wb_clk_i);
            cmd_valid = 1'b0;
            if (ph == 1) begin
                wbm_ack_i = 1'b1; wbm_dat_i = $urandom;
                @(negedge wb_clk_i);
                wbm_ack_i = 1'b0;
            end
            n_vec++;
            if (wbm_stb_o !== (ph == 0) || rsp_valid !== (ph == 1)) begin
                n_err++; $display("FAIL abort_setup phase %0d: stb=%b rv=%b", ph, wbm_stb_o, rsp_valid);
            end
            wb_rst_i = 1'b1;
            @(negedge wb_clk_i);
            wb_rst_i = 1'b0; wbm_ack_i = 1'b1; wbm_dat_i = $urandom;
            exp_count = 16'h0; last_dat = 32'h0; last_err = 1'b0;
            for (int c = 0; c < 3; c++) begin
                n_vec++;
                if (bus !== 71'h0 || rsp_valid !== 1'b0 || txn_count !== 16'h0 || rsp_dat !== 32'h0 ||
                    (c > 0 && cmd_ready !== 1'b1)) begin
                    n_err++;
                    $display("FAIL abort phase %0d cycle %0d: bus=%h rv=%b cnt=%h dat=%h rdy=%b required 0/0/0/0/1",
                             ph, c, bus, rsp_valid, txn_count, rsp_dat, cmd_ready);
                end
                @(negedge wb_clk_i);
            end
            wbm_ack_i = 1'b0;
        end
    endtask

    task automatic test_wrap;
        force dut.txn_cnt_r = 16'hFFFF;
        @(posedge wb_clk_i);
        #1 release dut.txn_cnt_r;
        @(negedge wb_clk_i);
        exp_count = 16'hFFFF;
        n_vec++;
        if (txn_count !== 16'hFFFF) begin
            n_err++; $display("FAIL preload: txn_count=%h required ffff", txn_count);
        end
        do_txn(1'b0, 4'hF, 32'h5000_0000, 32'h0, 0, 32'h1357_9BDF, 0, 1'b0, 1'b0);
        // Acks while idle must not touch anything.
        wbm_ack_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            wbm_dat_i = $urandom;
            @(negedge wb_clk_i);
            n_vec++;
            if (txn_count !== exp_count || rsp_valid !== 1'b0 || bus !== 71'h0 || cmd_ready !== 1'b1 ||
                rsp_dat !== last_dat || rsp_err !== last_err) begin
                n_err++;
                $display("FAIL idle_ack cycle %0d: cnt=%h rv=%b bus=%h rdy=%b dat=%h err=%b required cnt=%h rv=0 bus=0 rdy=1 dat=%h err=%b",
                         c, txn_count, rsp_valid, bus, cmd_ready, rsp_dat, rsp_err, exp_count, last_dat, last_err);
            end
        end
        wbm_ack_i = 1'b0;
    endtask

    initial begin
        test_reset;
        test_write_basic;
        test_read_wait;
        test_timeout;
        test_backpressure;
        test_back_to_back;
        test_reset_abort;
        test_wrap;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/wb_initiator.md
WB_INITIATOR -- requirements
Module: wb_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, the maximum number of cycles the bus phase waits for wbm_ack_i; legal range 1..65535.
REQ-002 SHALL have port wb_clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port wb_rst_i  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port cmd_valid  input  1  command request.
REQ-005 SHALL have port cmd_ready  output  1  the block accepts a command this cycle.
REQ-006 SHALL have port cmd_we  input  1  1 = write, 0 = read.
REQ-007 SHALL have port cmd_sel  input  4  byte select.
REQ-008 SHALL have port cmd_adr  input  32  address.
REQ-009 SHALL have port cmd_dat  input  32  write data.
REQ-010 SHALL have port rsp_valid  output  1  response available.
REQ-011 SHALL have port rsp_ready  input  1  response consumed.
REQ-012 SHALL have port rsp_dat  output  32  read data; 0 for writes and timeouts.
REQ-013 SHALL have port rsp_err  output  1  1 = transaction timed out.
REQ-014 SHALL have Wishbone initiator ports wbm_cyc_o, wbm_stb_o, wbm_we_o (output, 1 each), wbm_sel_o (output, 4), wbm_adr_o and wbm_dat_o (output, 32 each), wbm_dat_i (input, 32) and wbm_ack_i (input, 1).
REQ-015 SHALL have port txn_count  output  16  count of transactions that completed with ack.

Function
REQ-016 SHALL implement a three-state FSM: IDLE, BUS and RESP.
REQ-017 IDLE: cmd_ready=1 and all wbm_* outputs are 0; when cmd_valid=1, the block captures we/sel/adr/dat at that edge and moves to BUS.
REQ-018 BUS: wbm_cyc_o=wbm_stb_o=1 and wbm_we_o/sel/adr/dat hold the captured values, stable for the whole phase; cmd_ready=0.
REQ-019 All wbm_* outputs SHALL be registered; the first cycle with stb=1 is the cycle after command acceptance.
REQ-020 BUS, wbm_ack_i=1: for a read, wbm_dat_i is latched into rsp_dat (0 for a write); rsp_err is set to 0; txn_count increments; cyc and stb are 0 from the next cycle; the FSM moves to RESP.
REQ-021 The timeout counter (16 bits) SHALL clear on entry to BUS and increment on each BUS cycle without ack.
REQ-022 If the counter equals TIMEOUT_CYCLES-1 and wbm_ack_i=0, the block SHALL drop cyc/stb next cycle, set rsp_dat=0 and rsp_err=1, leave txn_count unchanged, and move to RESP.
REQ-023 Ack and timeout in the same cycle: ack wins.
REQ-024 RESP: rsp_valid=1 with rsp_dat/rsp_err stable until rsp_ready=1; on that edge rsp_valid clears and the FSM returns to IDLE; cmd_ready=0 throughout.
REQ-025 Minimum latency from command accept edge N SHALL be: stb high in cycle N+1; with ack in N+1, rsp_valid high in cycle N+2.
REQ-026 Back-to-back throughput SHALL be one transaction per 3 cycles minimum (IDLE, BUS, RESP each at least one cycle).
REQ-027 wbm_ack_i in IDLE or RESP SHALL be ignored: no state, data or count change.
REQ-028 cmd_sel=4'h0 SHALL still issue a bus cycle, with sel=0.
REQ-029 txn_count SHALL wrap from 16'hFFFF to 16'h0000.
REQ-030 rsp_dat and rsp_err SHALL hold their last values in IDLE; only rsp_valid qualifies them.

Reset
REQ-031 While wb_rst_i=1 at a clock edge: state=IDLE, all wbm_* outputs=0, rsp_valid=0, rsp_dat=0, rsp_err=0, timeout counter=0, txn_count=0; cmd_ready=1 from the first cycle after reset deasserts.
REQ-032 Reset during BUS or RESP SHALL abort the transaction: cyc/stb drop on the reset edge, no response is produced, and a late ack is ignored.

Verification
REQ-033 Write adr=0x3000_0000 dat=0x0000_0005 sel=0xF, ack in first stb cycle -> wbm_we_o=1 with adr/dat/sel matching for exactly 1 cycle; rsp_valid in cycle N+2 with rsp_err=0, rsp_dat=0; txn_count=1.
REQ-034 Read adr=0x3000_0000, ack after 3 wait cycles with wbm_dat_i=0x1234_5678 -> stb high 4 cycles, outputs stable throughout; rsp_dat=0x1234_5678, rsp_err=0.
REQ-035 TIMEOUT_CYCLES=4, no ack -> stb high exactly 4 cycles; rsp_err=1, rsp_dat=0, txn_count unchanged; ack arriving in the 4th stb cycle instead -> rsp_err=0.
REQ-036 rsp_ready held 0 for 5 cycles with cmd_valid=1 -> rsp_valid and data held, cmd_ready=0, no new stb; after rsp_ready=1 the next command is accepted in IDLE.
REQ-037 wb_rst_i=1 during BUS, then ack asserted -> cyc/stb=0 after the reset edge, rsp_valid never asserts, txn_count=0.
REQ-038 Preload 0xFFFF completed transactions (or force the count), then one more ack'd transaction -> txn_count=0x0000; a spurious ack in IDLE leaves it unchanged.
